histogram_readout: RTL
======================

Name: histogram_readout

Overview:
- Reader-side engine for the 1024-bin pixel histogram RAM. The pixel accumulator writes the bins; this block reads them.
- On a start pulse, walks every bin address, reads each 32-bit count and streams it out on a valid/ready word interface. The stream is framed by a header word and a checksum trailer.
- Optionally clears each bin to zero after reading, so the histogram is ready for the next frame.
- Sits between the histogram RAM port and the host/USB transmit path.

Parameters:
- NUM_BINS, 1024, number of histogram bins read per frame.
- ADDR_W, 10, bin address width; NUM_BINS <= 2^ADDR_W.
- DATA_W, 32, bin count width and stream word width.
- HEADER_TAG, 16'hA5A5, upper half of the header word.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  one-cycle request to begin a readout; honoured only in IDLE.
- clear_en_i  input  1  sampled with start_i; 1 = zero each bin after reading it.
- busy_o  output  1  high from accepted start through the DONE state.
- done_o  output  1  one-cycle pulse after the trailer handshake.
- frame_id_o  output  16  count of completed readouts.
- hist_addr_o  output  ADDR_W  bin address to the histogram RAM.
- hist_write_o  output  1  write strobe to the histogram RAM.
- hist_data_o  output  DATA_W  write data to the histogram RAM; constant 0.
- hist_data_i  input  DATA_W  RAM read data; valid 1 cycle after hist_addr_o is presented with hist_write_o=0.
- tx_data_o  output  DATA_W  stream word.
- tx_valid_o  output  1  stream word valid.
- tx_ready_i  input  1  downstream ready.
- tx_last_o  output  1  high with the trailer word only.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - All outputs 0: busy, done, addr, write, tx_data, tx_valid, tx_last, frame_id.
  - Internal checksum and bin counter are cleared.
  - A reset mid-readout abandons the frame. No further RAM writes are issued. Bins not yet visited keep their values.
- Handshake: a word transfers on a cycle where tx_valid_o=1 and tx_ready_i=1.
  - Once tx_valid_o rises, tx_data_o and tx_last_o are held stable until the transfer.
  - tx_valid_o never drops without a transfer.
- FSM states:
  - IDLE: on start_i=1, latch clear_en_i into clr_q; checksum=0; bin=0; go to HEADER. start_i in any other state is ignored.
  - HEADER: tx_data_o={HEADER_TAG, frame_id_o}, tx_valid_o=1. On transfer, go to RD.
  - RD: hist_addr_o=bin, hist_write_o=0. Next cycle go to CAP.
  - CAP: register hist_data_i into tx_data_o; checksum += hist_data_i (mod 2^DATA_W). If clr_q=1, assert hist_write_o=1 for this one cycle at the same address (data 0). Go to SEND.
  - SEND: tx_valid_o=1. On transfer:
    - if bin==NUM_BINS-1, go to TRAIL;
    - otherwise bin+1, go to RD.
  - TRAIL: tx_data_o=checksum, tx_last_o=1, tx_valid_o=1. On transfer, frame_id_o+1 (wraps 16'hFFFF->0) and go to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o still 1. Then go to IDLE.
- hist_addr_o holds the current bin in RD/CAP/SEND and is 0 in other states. hist_write_o is high only in CAP with clr_q=1.
- Throughput: at best 3 cycles per bin. A frame is NUM_BINS+2 words.
- clear_en_i is ignored outside the start cycle.

Test Plan:
1. Assert reset=0 mid-clock with random inputs -> every output is 0 immediately; after release, no activity until start_i.
2. RAM model bin[i]=i, clear_en=0, tx_ready=1, start -> 1026 words:
   - header 0xA5A50000, then words 0..1023, then trailer 0x0007FE00 with tx_last;
   - done_o pulses once, frame_id_o=1;
   - RAM unchanged, hist_write_o never high.
3. Same preload with clear_en=1 -> identical stream; hist_write_o is high once per bin, 1024 total. Second start -> header 0xA5A50001, all 1024 bin words 0, trailer 0x00000000.
4. tx_ready_i low for 5 cycles while bin 7 is in SEND -> tx_data_o=7 held stable, hist_addr_o stays 7, no duplicate or dropped words; full stream and checksum still correct.
5. start_i pulsed during bin 300 -> ignored, stream unaffected. reset=0 at bin 500 with clear_en=1 -> bins 0..499 are 0, bins 500..1023 intact. Next start -> header 0xA5A50000.
6. All bins 0xFFFFFFFF -> trailer 0xFFFFFC00 (checksum wraps mod 2^32).

Source files
------------

// File: rtl/histogram_readout.sv
// Histogram RAM reader: streams a header, every bin count and a checksum trailer
// over a valid/ready word interface, optionally zeroing each bin after it is read.
module histogram_readout #(
  parameter int          NUM_BINS   = 1024,
  parameter int          ADDR_W     = 10,
  parameter int          DATA_W     = 32,
  parameter logic [15:0] HEADER_TAG = 16'hA5A5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              clear_en_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       frame_id_o,
  output logic [ADDR_W-1:0] hist_addr_o,
  output logic              hist_write_o,
  output logic [DATA_W-1:0] hist_data_o,
  input  logic [DATA_W-1:0] hist_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              tx_last_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_RD,
    S_CAP,
    S_SEND,
    S_TRAIL,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] bin_reg, bin_next;
  logic              clr_reg, clr_next;
  logic [DATA_W-1:0] checksum_reg, checksum_next;
  logic [DATA_W-1:0] word_reg, word_next;
  logic [15:0]       frame_id_reg, frame_id_next;
  logic [DATA_W-1:0] header_word;

  assign header_word = DATA_W'({HEADER_TAG, frame_id_reg});
  assign hist_data_o = '0;
  assign frame_id_o  = frame_id_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      bin_reg      <= '0;
      clr_reg      <= 1'b0;
      checksum_reg <= '0;
      word_reg     <= '0;
      frame_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      clr_reg      <= clr_next;
      checksum_reg <= checksum_next;
      word_reg     <= word_next;
      frame_id_reg <= frame_id_next;
    end
  end

  // All stream and RAM outputs decode from registered state, so they fall to
  // zero the instant reset asserts and stay stable while a word is stalled.
  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    clr_next      = clr_reg;
    checksum_next = checksum_reg;
    word_next     = word_reg;
    frame_id_next = frame_id_reg;
    busy_o        = (state_reg != S_IDLE);
    done_o        = 1'b0;
    hist_addr_o   = '0;
    hist_write_o  = 1'b0;
    tx_data_o     = '0;
    tx_valid_o    = 1'b0;
    tx_last_o     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          clr_next      = clear_en_i;
          checksum_next = '0;
          bin_next      = '0;
          state_next    = S_HEADER;
        end
      end
      S_HEADER: begin
        tx_data_o  = header_word;
        tx_valid_o = 1'b1;
        if (tx_ready_i) state_next = S_RD;
      end
      S_RD: begin
        hist_addr_o = bin_reg;
        state_next  = S_CAP;
      end
      S_CAP: begin
        // Read data is valid here; the optional clear reuses the same address.
        hist_addr_o   = bin_reg;
        hist_write_o  = clr_reg;
        word_next     = hist_data_i;
        checksum_next = checksum_reg + hist_data_i;
        state_next    = S_SEND;
      end
      S_SEND: begin
        hist_addr_o = bin_reg;
        tx_data_o   = word_reg;
        tx_valid_o  = 1'b1;
        if (tx_ready_i) begin
          if (bin_reg == LAST_BIN) begin
            state_next = S_TRAIL;
          end else begin
            bin_next   = bin_reg + 1'b1;
            state_next = S_RD;
          end
        end
      end
      S_TRAIL: begin
        tx_data_o  = checksum_reg;
        tx_valid_o = 1'b1;
        tx_last_o  = 1'b1;
        if (tx_ready_i) begin
          frame_id_next = frame_id_reg + 16'd1;
          state_next    = S_DONE;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
